// File: rtl/result_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_reader_pkg
//  Description : Shared types, sizes and byte-select helper for the result
//                readout path of the carry-select adder board controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package result_reader_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 4;
    localparam int IDX_W     = 2;
    localparam int DATA_W    = BYTE_W * NUM_BYTES;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Pick one display byte out of the captured word; index 0 is bits 7:0.
    function automatic logic [BYTE_W-1:0] select_byte(
        input logic [DATA_W-1:0] word,
        input logic [IDX_W-1:0]  idx
    );
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = word[BYTE_W-1:0];
            2'd1:    b = word[2*BYTE_W-1:BYTE_W];
            2'd2:    b = word[3*BYTE_W-1:2*BYTE_W];
            default: b = word[4*BYTE_W-1:3*BYTE_W];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_byte_reader_step_lock.sv
`default_nettype none
// ============================================================================
//  Module      : step_lock
//  Description : Button lock for the byte-step button. A step fires at most
//                once until unlock re-arms it; force_lock arms the lock
//                without firing (used when a capture swallows a press).
//  Revision    : 1.0 - initial release
// ============================================================================
module step_lock (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic unlock,
    input  logic force_lock,
    output logic fire
);

    logic r_lock;

    // A press is honoured only while unlocked and not swallowed by a capture.
    assign fire = step & ~r_lock & ~force_lock;

    // Lock bit: setting (fire or forced) wins over unlock; unlock alone clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (force_lock || fire) begin
            r_lock <= 1'b1;
        end else if (unlock) begin
            r_lock <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_byte_reader.sv
`default_nettype none
// ============================================================================
//  Module      : result_byte_reader
//  Description : Captures the 32-bit adder sum and carry-out into a shadow
//                register and shows it one byte at a time on the LEDs,
//                stepped by a locked button.
//                Optional macro RESULT_AUTOSCROLL_EN adds a dwell counter
//                that advances the byte every SCROLL_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_byte_reader
    import result_reader_pkg::*;
#(
    parameter int SCROLL_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] sum,
    input  logic              cout_in,
    input  logic              step,
    input  logic              unlock,
    output logic [BYTE_W-1:0] out,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              cout_led,
    output logic              valid,
    output logic              done
);

    if (SCROLL_CYCLES < 2) begin : g_scroll_check
        $error("SCROLL_CYCLES must be at least 2");
    end

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shadow, w_shadow_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [BYTE_W-1:0] r_out, w_out_nxt;
    logic              r_cout, w_cout_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_done, w_done_nxt;

    logic w_show_step;
    logic w_force_lock;
    logic w_fire;
    logic w_auto_adv;
    logic w_adv;

    // Step only counts while showing; a capture in SHOW swallows the press.
    assign w_show_step  = step & (r_state == SHOW);
    assign w_force_lock = w_show_step & load;

    step_lock u_step_lock (
        .clk        (clk),
        .rst        (rst),
        .step       (w_show_step),
        .unlock     (unlock),
        .force_lock (w_force_lock),
        .fire       (w_fire)
    );

`ifdef RESULT_AUTOSCROLL_EN
    localparam logic [31:0] c_DWELL_LAST = 32'(SCROLL_CYCLES - 1);
    logic [31:0] r_dwell;

    assign w_auto_adv = (r_state == SHOW) && !load && (r_dwell == c_DWELL_LAST);

    // Dwell counter restarts on any advance or capture and idles at 0 outside SHOW.
    always_ff @(posedge clk) begin
        if (rst || (r_state != SHOW) || load || w_fire || w_auto_adv) begin
            r_dwell <= 32'd0;
        end else begin
            r_dwell <= r_dwell + 32'd1;
        end
    end
`else
    assign w_auto_adv = 1'b0;
`endif

    assign w_adv = w_fire | w_auto_adv;

    // Next-state and next-output logic; capture takes priority over any advance.
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_idx_nxt    = r_idx;
        w_cout_nxt   = r_cout;
        w_valid_nxt  = r_valid;
        w_done_nxt   = r_done;
        if (load) begin
            w_state_nxt  = SHOW;
            w_shadow_nxt = sum;
            w_cout_nxt   = cout_in;
            w_idx_nxt    = '0;
            w_done_nxt   = 1'b0;
            w_valid_nxt  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                SHOW: begin
                    if (w_adv) begin
                        w_idx_nxt = r_idx + 1'b1;
                        if (r_idx == IDX_W'(NUM_BYTES - 1)) begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_out_nxt = (w_state_nxt == SHOW) ? select_byte(w_shadow_nxt, w_idx_nxt) : '0;
    end

    // State and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_idx    <= '0;
            r_out    <= '0;
            r_cout   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_idx    <= w_idx_nxt;
            r_out    <= w_out_nxt;
            r_cout   <= w_cout_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign out      = r_out;
    assign byte_idx = r_idx;
    assign cout_led = r_cout;
    assign valid    = r_valid;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_byte_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_byte_reader
//  Description : Self-checking bench for result_byte_reader with a
//                behavioural reference model and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_byte_reader;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] sum = 32'd0;
    logic        cout_in = 1'b0;
    logic        step = 1'b0;
    logic        unlock = 1'b0;
    logic [7:0]  out;
    logic [1:0]  byte_idx;
    logic        cout_led;
    logic        valid;
    logic        done;

    logic [12:0] obs;
    assign obs = {out, byte_idx, cout_led, valid, done};

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_show;
    logic [31:0] m_sh;
    int          m_idx;
    bit          m_lock, m_done, m_valid, m_cout;
    int          m_dwell;

    result_byte_reader #(.SCROLL_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .sum      (sum),
        .cout_in  (cout_in),
        .step     (step),
        .unlock   (unlock),
        .out      (out),
        .byte_idx (byte_idx),
        .cout_led (cout_led),
        .valid    (valid),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] exp_pack();
        logic [31:0] shifted;
        logic [7:0]  b;
        shifted = m_sh >> (8 * m_idx);
        b = m_show ? shifted[7:0] : 8'h00;
        return {b, 2'(m_idx), m_cout, m_valid, m_done};
    endfunction

    // Drive one cycle of inputs, advance the reference model at the edge,
    // then settle just past the edge for sampling.
    task automatic tick(input bit r, input bit ld, input logic [31:0] s,
                        input bit c, input bit st, input bit ul);
        bit adv;
        rst = r; load = ld; sum = s; cout_in = c; step = st; unlock = ul;
        @(posedge clk);
        adv = 1'b0;
        if (r) begin
            m_show = 0; m_sh = 0; m_idx = 0; m_lock = 0;
            m_done = 0; m_valid = 0; m_cout = 0; m_dwell = 0;
        end else if (ld) begin
            if (m_show && st) m_lock = 1;
            else if (ul)      m_lock = 0;
            m_show = 1; m_sh = s; m_cout = c; m_idx = 0;
            m_done = 0; m_valid = 1; m_dwell = 0;
        end else if (m_show) begin
            if (st && !m_lock) begin
                adv = 1'b1;
                m_lock = 1;
            end else if (ul) begin
                m_lock = 0;
            end
`ifdef RESULT_AUTOSCROLL_EN
            if (m_dwell == SC - 1) adv = 1'b1;
            m_dwell = adv ? 0 : m_dwell + 1;
`endif
            if (adv) begin
                m_idx = (m_idx + 1) % 4;
                if (m_idx == 0) m_done = 1;
            end
        end else begin
            if (ul) m_lock = 0;
            m_dwell = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 32'hFFFF_FFFF, 1, 1, 1);
        tick(1, 1, 32'hFFFF_FFFF, 1, 0, 0);
        checks++;
        if (obs !== 13'h0000) begin
            failures++;
            $display("FAIL reset got=%h expected=%h", obs, 13'h0000);
        end
    endtask

    task automatic test_capture();
        tick(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        checks++;
        if (obs !== {8'hEF, 2'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL capture got=%h expected=%h", obs, {8'hEF, 2'd0, 1'b1, 1'b1, 1'b0});
        end
        tick(0, 0, $urandom(), 0, 0, 0);
        checks++;
        if (obs !== {8'hEF, 2'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL capture_hold got=%h expected=%h", obs, {8'hEF, 2'd0, 1'b1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_step_sequence();
        logic [7:0]  exp_b [4];
        logic [12:0] e;
        exp_b = '{8'hBE, 8'hAD, 8'hDE, 8'hEF};
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 32'h0, 0, 1, 0);
            e = {exp_b[i], 2'((i + 1) % 4), 1'b1, 1'b1, (i == 3)};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL step_seq%0d got=%h expected=%h", i, obs, e);
            end
            tick(0, 0, 32'h0, 0, 0, 1);
        end
    endtask

    task automatic test_held_step();
        logic [12:0] e;
        for (int i = 0; i < 20; i++) tick(0, 0, 32'h0, 0, 1, 0);
        e = {8'hBE, 2'd1, 1'b1, 1'b1, 1'b1};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL held_step got=%h expected=%h", obs, e);
        end
        tick(0, 0, 32'h0, 0, 1, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL step_unlock_locked got=%h expected=%h", obs, e);
        end
        tick(0, 0, 32'h0, 0, 1, 0);
        e = {8'hAD, 2'd2, 1'b1, 1'b1, 1'b1};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL step_after_unlock got=%h expected=%h", obs, e);
        end
    endtask

    task automatic test_load_with_step();
        logic [12:0] e;
        tick(0, 0, 32'h0, 0, 0, 1);
        tick(0, 1, 32'h1234_5678, 0, 1, 0);
        e = {8'h78, 2'd0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL load_step got=%h expected=%h", obs, e);
        end
        for (int i = 0; i < 5; i++) tick(0, 0, 32'h0, 0, 1, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL load_step_held got=%h expected=%h", obs, e);
        end
        tick(0, 0, 32'h0, 0, 1, 1);
        tick(0, 0, 32'h0, 0, 1, 0);
        e = {8'h56, 2'd1, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL load_step_rearm got=%h expected=%h", obs, e);
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 32'h0, 0, 0, 1);
        tick(0, 0, 32'h0, 0, 1, 0);
        checks++;
        if (byte_idx !== 2'd2) begin
            failures++;
            $display("FAIL mid_idx got=%0d expected=2", byte_idx);
        end
        tick(1, 0, 32'h0, 0, 1, 0);
        checks++;
        if (obs !== 13'h0000) begin
            failures++;
            $display("FAIL reset_mid got=%h expected=%h", obs, 13'h0000);
        end
        tick(0, 0, 32'hCAFE_F00D, 1, 1, 0);
        tick(0, 0, 32'hCAFE_F00D, 1, 1, 1);
        checks++;
        if (obs !== 13'h0000) begin
            failures++;
            $display("FAIL idle_step got=%h expected=%h", obs, 13'h0000);
        end
    endtask

`ifdef RESULT_AUTOSCROLL_EN
    task automatic test_autoscroll();
        tick(0, 1, 32'hA1B2_C3D4, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 32'h0, 0, 0, 0);
            checks++;
            if (obs !== exp_pack()) begin
                failures++;
                $display("FAIL autoscroll%0d got=%h expected=%h", i, obs, exp_pack());
            end
        end
        checks++;
        if (done !== 1'b1 || byte_idx !== 2'd0) begin
            failures++;
            $display("FAIL autoscroll_done got=%b/%0d expected=1/0", done, byte_idx);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 60) == 0), ($urandom_range(0, 12) == 0), $urandom(),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0));
            checks++;
            if (obs !== exp_pack()) begin
                failures++;
                $display("FAIL random%0d got=%h expected=%h", i, obs, exp_pack());
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_step_sequence();
        test_held_step();
        test_load_with_step();
        test_reset_mid();
`ifdef RESULT_AUTOSCROLL_EN
        test_autoscroll();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
